bus_sync_tx_sched: RTL and testbench

Source-domain scheduler that shares one multi-bit CDC channel (the enable-pulse bus synchronizer) between several requesters. It round-robin arbitrates requests, then drives the synchronizer's unsynchronized data bus and its level enable. The enable is held long enough for the destination domain to capture the data, followed by a mandatory low gap so that each transfer produces exactly one destination enable pulse. The block sits in the source clock domain, directly upstream of the synchronizer's Unsync_bus/bus_enable inputs.

---
 rtl/bus_sync_tx_sched_if.sv | 22 ++
 rtl/bus_sync_tx_sched.sv | 139 +++++++++++++
 tb/tb_bus_sync_tx_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_sync_tx_sched_if.sv
// Request/grant side and synchronizer-facing outputs of the CDC transfer scheduler.
interface bus_sync_tx_sched_if #(
   parameter int NUM_REQ   = 4,
   parameter int BUS_WIDTH = 8
);
   logic [NUM_REQ-1:0]           req;
   logic [NUM_REQ*BUS_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]           ack;
   logic [BUS_WIDTH-1:0]         Unsync_bus;
   logic                         bus_enable;
   logic                         busy;

   modport master (
      input  req, req_data,
      output ack, Unsync_bus, bus_enable, busy
   );

   modport slave (
      output req, req_data,
      input  ack, Unsync_bus, bus_enable, busy
   );
endinterface

// File: rtl/bus_sync_tx_sched.sv
// Round-robin scheduler feeding one enable-pulse bus synchronizer: enable held
// HOLD_CYCLES, then a GAP_CYCLES low gap so each transfer gives one destination pulse.
//
// state | meaning
// IDLE  | bus_enable low, sampling req for the next grant
// HOLD  | bus_enable high, Unsync_bus frozen while the destination captures
// GAP   | bus_enable low, Unsync_bus kept, guarantees an enable low phase
module bus_sync_tx_sched #(
   parameter int NUM_REQ     = 4,
   parameter int BUS_WIDTH   = 8,
   parameter int HOLD_CYCLES = 4,
   parameter int GAP_CYCLES  = 4
) (
   input  logic                 CLK,
   input  logic                 RST,
   bus_sync_tx_sched_if.master  bus
);

   localparam int PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int MAX_C  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int CNT_W  = (MAX_C > 0) ? $clog2(MAX_C + 1) : 1;
   localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_t;

   state_t               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic                 en_q, en_d;

   logic                 win_found;
   logic [PTR_W-1:0]     win_idx;
   logic [BUS_WIDTH-1:0] sel_data;

   // Search starts just after the last winner so every requester gets a turn.
   function automatic logic [PTR_W:0] rr_pick(
      input logic [NUM_REQ-1:0] r,
      input logic [PTR_W-1:0]   p
   );
      logic             found;
      logic [PTR_W-1:0] idx;
      int               c;
      found = 1'b0;
      idx   = p;
      for (int i = 1; i <= NUM_REQ; i++) begin
         c = int'(p) + i;
         if (c >= NUM_REQ) c = c - NUM_REQ;
         if (!found && r[c[PTR_W-1:0]]) begin
            found = 1'b1;
            idx   = c[PTR_W-1:0];
         end
      end
      return {found, idx};
   endfunction

   always_comb begin
      {win_found, win_idx} = rr_pick(bus.req, ptr_q);
   end

   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win_idx == PTR_W'(i)) sel_data = bus.req_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= PTR_W'(NUM_REQ - 1);
         ack_q   <= '0;
         data_q  <= '0;
         en_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
         en_q    <= en_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      ack_d   = '0;
      data_d  = data_q;
      en_d    = en_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               data_d         = sel_data;
               en_d           = 1'b1;
               ack_d[win_idx] = 1'b1;
               ptr_d          = win_idx;
               cnt_d          = HOLD_LOAD;
               state_d        = HOLD;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               en_d    = 1'b0;
               cnt_d   = GAP_LOAD;
               state_d = GAP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            en_d    = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   assign bus.ack        = ack_q;
   assign bus.Unsync_bus = data_q;
   assign bus.bus_enable = en_q;
   assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_bus_sync_tx_sched.sv
// Scoreboard bench: three scheduler instances (hold/gap 4/4, 1/1, 7/3) share
// stimulus; a negedge monitor pops expected grants and checks enable timing.
module tb_bus_sync_tx_sched;

   localparam int NR = 4;
   localparam int BW = 8;
   localparam int ND = 3;

   function automatic int hold_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 7;
      endcase
   endfunction

   function automatic int gap_of(input int k);
      case (k)
         0:       return 4;
         1:       return 1;
         default: return 3;
      endcase
   endfunction

   typedef struct packed {
      logic [1:0] idx;
      logic [7:0] data;
      logic       b2b;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_v  [ND];
   logic [NR*BW-1:0] rdata;
   logic [NR-1:0]    ack_w  [ND];
   logic [BW-1:0]    ub_w   [ND];
   logic             en_w   [ND];
   logic             busy_w [ND];

   exp_t exp_q [ND][$];
   int   errors = 0;
   int   checks = 0;
   int   ack_cnt [ND];
   int   target  [ND];
   int   stop_at [ND];
   bit   auto_drop;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      bus_sync_tx_sched_if #(.NUM_REQ(NR), .BUS_WIDTH(BW)) bif ();
      assign bif.req      = req_v[g];
      assign bif.req_data = rdata;
      bus_sync_tx_sched #(
         .NUM_REQ(NR), .BUS_WIDTH(BW),
         .HOLD_CYCLES(hold_of(g)), .GAP_CYCLES(gap_of(g))
      ) dut (
         .CLK(clk),
         .RST(rst),
         .bus(bif.master)
      );
      assign ack_w[g]  = bif.ack;
      assign ub_w[g]   = bif.Unsync_bus;
      assign en_w[g]   = bif.bus_enable;
      assign busy_w[g] = bif.busy;
   end

   task automatic check(input string name, input bit ok, input longint act, input longint expv);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic push(input int k, input int idx, input logic [7:0] d, input bit b2b);
      exp_t e;
      e.idx  = 2'(idx);
      e.data = d;
      e.b2b  = b2b;
      exp_q[k].push_back(e);
   endtask

   // One clock, then requesters react to what they see (drop on own ack, or stop after N grants).
   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
         if (auto_drop) req_v[k] = req_v[k] & ~ack_w[k];
         if (ack_cnt[k] >= stop_at[k]) req_v[k] = '0;
      end
   endtask

   task automatic wait_targets(input int budget);
      int  c;
      bit  done;
      c = 0;
      done = 1'b0;
      while (!done && c < budget) begin
         done = 1'b1;
         for (int k = 0; k < ND; k++) if (ack_cnt[k] < target[k]) done = 1'b0;
         if (!done) begin
            step();
            c++;
         end
      end
      if (!done) check("grant_timeout", 1'b0, c, budget);
   endtask

   task automatic wait_idle(input int budget);
      int c;
      bit idle;
      c = 0;
      idle = 1'b0;
      while (!idle && c < budget) begin
         idle = 1'b1;
         for (int k = 0; k < ND; k++) if (busy_w[k] || exp_q[k].size() != 0) idle = 1'b0;
         if (!idle) begin
            step();
            c++;
         end
      end
      if (!idle) check("idle_timeout", 1'b0, c, budget);
      repeat (3) step();
   endtask

   task automatic do_reset();
      for (int k = 0; k < ND; k++) req_v[k] = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
   endtask

   task automatic sync_targets();
      for (int k = 0; k < ND; k++) target[k] = ack_cnt[k];
   endtask

   // Monitor / scoreboard
   initial begin
      int         cyc;
      bit         prev_en [ND];
      bit         prev_busy [ND];
      bit         seen_fall [ND];
      int         hi [ND];
      int         lo [ND];
      int         bcnt [ND];
      int         last_g [ND];
      logic [7:0] held [ND];
      bit         rise, fall;
      int         h, gp;
      exp_t       e;
      cyc = 0;
      for (int k = 0; k < ND; k++) begin
         ack_cnt[k] = 0;
         prev_en[k] = 1'b0; prev_busy[k] = 1'b0; seen_fall[k] = 1'b0;
         hi[k] = 0; lo[k] = 0; bcnt[k] = 0; last_g[k] = -1; held[k] = '0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int k = 0; k < ND; k++) begin
            h  = hold_of(k);
            gp = gap_of(k);
            if (rst) begin
               prev_en[k] = 1'b0; prev_busy[k] = 1'b0; seen_fall[k] = 1'b0;
               hi[k] = 0; lo[k] = 0; bcnt[k] = 0; last_g[k] = -1;
            end else begin
               rise = en_w[k] && !prev_en[k];
               fall = !en_w[k] && prev_en[k];
               if (ack_w[k] != '0) begin
                  check($sformatf("d%0d ack_onehot", k), $onehot(ack_w[k]), ack_w[k], 1);
                  if (exp_q[k].size() == 0) begin
                     check($sformatf("d%0d unexpected_ack", k), 1'b0, ack_w[k], 0);
                  end else begin
                     e = exp_q[k].pop_front();
                     check($sformatf("d%0d ack_winner", k), ack_w[k] == (4'b0001 << e.idx),
                           ack_w[k], 1 << e.idx);
                     check($sformatf("d%0d grant_data", k), ub_w[k] == e.data, ub_w[k], e.data);
                     if (last_g[k] >= 0) begin
                        if (e.b2b)
                           check($sformatf("d%0d grant_period", k), cyc - last_g[k] == h + gp + 1,
                                 cyc - last_g[k], h + gp + 1);
                        else
                           check($sformatf("d%0d grant_spacing", k), cyc - last_g[k] >= h + gp + 1,
                                 cyc - last_g[k], h + gp + 1);
                     end
                  end
                  check($sformatf("d%0d enable_rise_with_ack", k), rise, rise, 1);
                  check($sformatf("d%0d busy_with_ack", k), busy_w[k], busy_w[k], 1);
                  last_g[k] = cyc;
                  held[k]   = ub_w[k];
                  ack_cnt[k]++;
               end else begin
                  if (rise) check($sformatf("d%0d rise_without_ack", k), 1'b0, 1, 0);
                  if (busy_w[k])
                     check($sformatf("d%0d data_stable", k), ub_w[k] == held[k], ub_w[k], held[k]);
               end
               if (rise) begin
                  if (seen_fall[k])
                     check($sformatf("d%0d enable_low_width", k), lo[k] >= gp + 1, lo[k], gp + 1);
                  hi[k] = 1;
               end else if (en_w[k]) begin
                  hi[k]++;
               end
               if (fall) begin
                  check($sformatf("d%0d enable_high_width", k), hi[k] == h, hi[k], h);
                  lo[k] = 1;
                  seen_fall[k] = 1'b1;
               end else if (!en_w[k]) begin
                  lo[k]++;
               end
               if (busy_w[k]) begin
                  bcnt[k]++;
               end else if (prev_busy[k]) begin
                  check($sformatf("d%0d busy_width", k), bcnt[k] == h + gp, bcnt[k], h + gp);
                  bcnt[k] = 0;
               end
               prev_en[k]   = en_w[k];
               prev_busy[k] = busy_w[k];
            end
         end
      end
   end

   // Stimulus
   initial begin
      auto_drop = 1'b1;
      rdata     = '0;
      for (int k = 0; k < ND; k++) begin
         req_v[k]   = '0;
         stop_at[k] = 1 << 30;
         target[k]  = 0;
      end
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < ND; k++) begin
         check($sformatf("d%0d reset_enable", k), en_w[k] == 1'b0, en_w[k], 0);
         check($sformatf("d%0d reset_bus", k), ub_w[k] == 8'h00, ub_w[k], 0);
         check($sformatf("d%0d reset_busy", k), busy_w[k] == 1'b0, busy_w[k], 0);
         check($sformatf("d%0d reset_ack", k), ack_w[k] == 4'b0000, ack_w[k], 0);
      end
      rst = 1'b0;
      step();

      // Single request on requester 1, then requester 2 arriving during the transfer
      rdata = 32'h005A_A500;
      sync_targets();
      for (int k = 0; k < ND; k++) begin
         req_v[k] = 4'b0010;
         push(k, 1, 8'hA5, 1'b0);
         target[k]++;
      end
      wait_targets(50);
      for (int k = 0; k < ND; k++) begin
         req_v[k] = 4'b0100;
         push(k, 2, 8'h5A, 1'b1);
         target[k]++;
      end
      wait_targets(50);
      wait_idle(60);

      // All four requesting continuously: 0,1,2,3,0 at the back-to-back period
      do_reset();
      auto_drop = 1'b0;
      rdata = 32'h1312_1110;
      sync_targets();
      for (int k = 0; k < ND; k++) begin
         req_v[k] = 4'b1111;
         push(k, 0, 8'h10, 1'b0);
         push(k, 1, 8'h11, 1'b1);
         push(k, 2, 8'h12, 1'b1);
         push(k, 3, 8'h13, 1'b1);
         push(k, 0, 8'h10, 1'b1);
         target[k]  = ack_cnt[k] + 5;
         stop_at[k] = target[k];
      end
      wait_targets(200);
      wait_idle(60);
      for (int k = 0; k < ND; k++) stop_at[k] = 1 << 30;
      auto_drop = 1'b1;

      // Round-robin skip: ptr=1, req=1001 -> 3 then 0
      do_reset();
      sync_targets();
      req_v[0] = 4'b0010;
      push(0, 1, 8'h11, 1'b0);
      target[0]++;
      wait_targets(50);
      req_v[0] = 4'b1001;
      push(0, 3, 8'h13, 1'b1);
      push(0, 0, 8'h10, 1'b1);
      target[0] += 2;
      wait_targets(80);
      wait_idle(60);

      // Late request: requester 2 raised mid-HOLD waits for the next IDLE
      do_reset();
      sync_targets();
      req_v[0] = 4'b0001;
      push(0, 0, 8'h10, 1'b0);
      target[0]++;
      wait_targets(50);
      step();
      req_v[0][2] = 1'b1;
      push(0, 2, 8'h12, 1'b1);
      target[0]++;
      step();
      check("late_req_no_ack", ack_w[0] == 4'b0000, ack_w[0], 0);
      check("late_req_inflight_bus", ub_w[0] == 8'h10, ub_w[0], 8'h10);
      wait_targets(50);
      wait_idle(60);

      // Reset two cycles into HOLD, then requester 0 wins again over requester 1
      do_reset();
      sync_targets();
      req_v[0] = 4'b0001;
      push(0, 0, 8'h10, 1'b0);
      target[0]++;
      wait_targets(50);
      step();
      check("pre_reset_enable", en_w[0] == 1'b1, en_w[0], 1);
      rst = 1'b1;
      #1;
      check("midhold_reset_enable", en_w[0] == 1'b0, en_w[0], 0);
      check("midhold_reset_bus", ub_w[0] == 8'h00, ub_w[0], 0);
      check("midhold_reset_busy", busy_w[0] == 1'b0, busy_w[0], 0);
      check("midhold_reset_ack", ack_w[0] == 4'b0000, ack_w[0], 0);
      step();
      rst = 1'b0;
      step();
      sync_targets();
      req_v[0] = 4'b0011;
      push(0, 0, 8'h10, 1'b0);
      push(0, 1, 8'h11, 1'b1);
      target[0] += 2;
      wait_targets(80);
      wait_idle(60);

      for (int k = 0; k < ND; k++)
         check($sformatf("d%0d scoreboard_drained", k), exp_q[k].size() == 0, exp_q[k].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
